csr_rw_unit: RTL and testbench

CSR_RW_UNIT -- requirements
Module: csr_rw_unit

---
 rtl/csr_rw_unit_pkg.sv | 25 ++
 rtl/csr_rw_unit_counter64.sv | 16 +
 rtl/csr_rw_unit.sv | 92 +++++++++
 tb/tb_csr_rw_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/csr_rw_unit_pkg.sv
// csr_rw_unit_pkg: CSR addresses, access op encodings, FSM states and the write-merge helper.
package csr_rw_unit_pkg;
  typedef enum logic [1:0] {
    OP_RO = 2'b00,
    OP_RW = 2'b01,
    OP_RS = 2'b10,
    OP_RC = 2'b11
  } csr_op_e;
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } csr_state_e;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  function automatic logic [31:0] csr_merge(input logic [1:0] op, input logic [31:0] old, input logic [31:0] wdata);
    return op == OP_RW ? wdata : op == OP_RS ? old | wdata : op == OP_RC ? old & ~wdata : old;
  endfunction
endpackage

// File: rtl/csr_rw_unit_counter64.sv
// csr_counter64: 64-bit counter whose halves can be overwritten; a write suppresses that edge's increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);
  always_ff @(posedge clk) begin
    if (rst) value <= '0;
    else if (wr_lo || wr_hi) value <= {wr_hi ? wdata : value[63:32], wr_lo ? wdata : value[31:0]};
    else if (inc) value <= value + 64'd1;
  end
endmodule

// File: rtl/csr_rw_unit.sv
// csr_rw_unit: machine-mode CSR read/modify/write unit with a one-cycle response.
// Define CSR_COUNTERS_EN to build mcycle/minstret and their addresses.
module csr_rw_unit
  import csr_rw_unit_pkg::*;
#(
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter logic [31:0] MTVEC_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_illegal,
  input  logic        retire
);
  csr_state_e state, next_state;
  logic [31:0] mtvec, mscratch, mepc, mcause;
  logic [31:0] cur, new_val, rdata_q;
  logic hit, is_write, illegal, accept, do_write, illegal_q;
`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret;
  csr_counter64 u_mcycle (
    .clk(clk), .rst(rst), .inc(1'b1),
    .wr_lo(do_write && req_addr == CSR_MCYCLE), .wr_hi(do_write && req_addr == CSR_MCYCLEH),
    .wdata(new_val), .value(mcycle)
  );
  csr_counter64 u_minstret (
    .clk(clk), .rst(rst), .inc(retire),
    .wr_lo(do_write && req_addr == CSR_MINSTRET), .wr_hi(do_write && req_addr == CSR_MINSTRETH),
    .wdata(new_val), .value(minstret)
  );
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif
  always_comb begin
    cur = '0;
    hit = 1'b1;
    case (req_addr)
      CSR_MHARTID:   cur = HART_ID;
      CSR_MTVEC:     cur = mtvec;
      CSR_MSCRATCH:  cur = mscratch;
      CSR_MEPC:      cur = mepc;
      CSR_MCAUSE:    cur = mcause;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    cur = mcycle[31:0];
      CSR_MCYCLEH:   cur = mcycle[63:32];
      CSR_MINSTRET:  cur = minstret[31:0];
      CSR_MINSTRETH: cur = minstret[63:32];
`endif
      default:       hit = 1'b0;
    endcase
  end
  // RS/RC with a zero operand are pure reads, so they may target read-only CSRs
  assign is_write   = req_op == OP_RW || (req_op[1] && |req_wdata);
  assign illegal    = !hit || (is_write && req_addr[11:10] == 2'b11);
  assign accept     = state == S_IDLE && req_valid && !rst;
  assign do_write   = accept && is_write && !illegal;
  assign new_val    = csr_merge(req_op, cur, req_wdata);
  assign next_state = state == S_IDLE && req_valid ? S_RESP : S_IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rdata_q   <= '0;
      illegal_q <= 1'b0;
      mtvec     <= MTVEC_RESET;
      mscratch  <= '0;
      mepc      <= '0;
      mcause    <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        rdata_q   <= illegal ? '0 : cur;
        illegal_q <= illegal;
      end
      if (do_write && req_addr == CSR_MTVEC)    mtvec    <= new_val;
      if (do_write && req_addr == CSR_MSCRATCH) mscratch <= new_val;
      if (do_write && req_addr == CSR_MEPC)     mepc     <= {new_val[31:2], 2'b00};
      if (do_write && req_addr == CSR_MCAUSE)   mcause   <= new_val;
    end
  end
  // Outputs are gated by rst so a pending response vanishes as soon as reset is asserted
  assign resp_valid   = state == S_RESP && !rst;
  assign req_ready    = state == S_IDLE || rst;
  assign resp_rdata   = resp_valid ? rdata_q : '0;
  assign resp_illegal = resp_valid && illegal_q;
endmodule

// File: tb/tb_csr_rw_unit.sv
// tb_csr_rw_unit: table vectors, corner sequences and random traffic against a CSR file model.
module tb_csr_rw_unit;
  localparam logic [31:0] HART = 32'h0000_0007;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, retire = 1'b0;
  logic req_ready, resp_valid, resp_illegal;
  logic [1:0] req_op = 2'b00;
  logic [11:0] req_addr = 12'h0;
  logic [31:0] req_wdata = 32'h0, resp_rdata;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;

  csr_rw_unit #(.HART_ID(HART), .MTVEC_RESET(32'h0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_illegal(resp_illegal),
    .retire(retire)
  );

  logic [31:0] m_mtvec = 0, m_mscratch = 0, m_mepc = 0, m_mcause = 0;
  logic [63:0] m_cyc = 0, m_ins = 0;
  logic m_pend = 0, m_pend_il = 0;
  logic [31:0] m_pend_rd = 0, got_rdata = 0;
  logic got_il = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic m_read(input logic [11:0] a, output logic ok, output logic [31:0] v);
    ok = 1'b1;
    v = 0;
    if (a == 12'hF14) v = HART;
    else if (a == 12'h305) v = m_mtvec;
    else if (a == 12'h340) v = m_mscratch;
    else if (a == 12'h341) v = m_mepc;
    else if (a == 12'h342) v = m_mcause;
`ifdef CSR_COUNTERS_EN
    else if (a == 12'hB00) v = m_cyc[31:0];
    else if (a == 12'hB80) v = m_cyc[63:32];
    else if (a == 12'hB02) v = m_ins[31:0];
    else if (a == 12'hB82) v = m_ins[63:32];
`endif
    else ok = 1'b0;
  endtask

  // One clock: check outputs against the model, then advance the model over the edge
  task automatic cycle(input logic r, input logic v, input logic [1:0] op, input logic [11:0] a,
                       input logic [31:0] wd, input logic ret);
    logic ok, w, il, acc;
    logic [31:0] old, nv;
    logic [63:0] nc, ni;
    rst = r; req_valid = v; req_op = op; req_addr = a; req_wdata = wd; retire = ret;
    #1;
    chk("req_ready", {31'b0, req_ready}, {31'b0, r || !m_pend});
    chk("resp_valid", {31'b0, resp_valid}, {31'b0, !r && m_pend});
    chk("resp_rdata", resp_rdata, (!r && m_pend) ? m_pend_rd : 32'h0);
    chk("resp_illegal", {31'b0, resp_illegal}, {31'b0, !r && m_pend && m_pend_il});
    got_rdata = resp_rdata;
    got_il = resp_illegal;
    if (r) begin
      m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
      m_cyc = 0; m_ins = 0; m_pend = 0;
    end else begin
      acc = v && !m_pend;
      nc = m_cyc + 64'd1;
      ni = m_ins + (ret ? 64'd1 : 64'd0);
`ifndef CSR_COUNTERS_EN
      ni = 0;
      nc = 0;
`endif
      if (acc) begin
        m_read(a, ok, old);
        w = (op == 2'b01) || (op[1] && wd != 0);
        il = !ok || (w && a[11:10] == 2'b11);
        nv = op == 2'b01 ? wd : op == 2'b10 ? (old | wd) : (old & ~wd);
        m_pend_rd = il ? 32'h0 : old;
        m_pend_il = il;
        if (w && !il) begin
          if (a == 12'h305) m_mtvec = nv;
          if (a == 12'h340) m_mscratch = nv;
          if (a == 12'h341) m_mepc = nv & ~32'h3;
          if (a == 12'h342) m_mcause = nv;
          if (a == 12'hB00) nc = {m_cyc[63:32], nv};
          if (a == 12'hB80) nc = {nv, m_cyc[31:0]};
          if (a == 12'hB02) ni = {m_ins[63:32], nv};
          if (a == 12'hB82) ni = {nv, m_ins[31:0]};
        end
      end
      m_cyc = nc;
      m_ins = ni;
      m_pend = acc;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic xact(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
    cycle(1'b0, 1'b1, op, a, wd, 1'($urandom % 2));
    cycle(1'b0, 1'b0, 2'b00, 12'h0, 32'h0, 1'($urandom % 2));
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        il;
  } vec_t;
  vec_t tbl[13];
  logic [11:0] addrs[12];

  initial begin
    tbl[0]  = '{2'b01, 12'h340, 32'hDEADBEEF, 32'h0, 1'b0};
    tbl[1]  = '{2'b01, 12'h340, 32'h0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{2'b10, 12'h305, 32'h0000_00F0, 32'h0, 1'b0};
    tbl[3]  = '{2'b11, 12'h305, 32'h0000_0030, 32'h0000_00F0, 1'b0};
    tbl[4]  = '{2'b10, 12'h305, 32'h0, 32'h0000_00C0, 1'b0};
    tbl[5]  = '{2'b01, 12'hF14, 32'h1, 32'h0, 1'b1};
    tbl[6]  = '{2'b10, 12'hF14, 32'h0, HART, 1'b0};
    tbl[7]  = '{2'b01, 12'h341, 32'hFFFF_FFFF, 32'h0, 1'b0};
    tbl[8]  = '{2'b11, 12'h341, 32'h0, 32'hFFFF_FFFC, 1'b0};
    tbl[9]  = '{2'b01, 12'h7C0, 32'h1, 32'h0, 1'b1};
    tbl[10] = '{2'b00, 12'h342, 32'h5, 32'h0, 1'b0};
    tbl[11] = '{2'b01, 12'h342, 32'h123, 32'h0, 1'b0};
    tbl[12] = '{2'b11, 12'h342, 32'h0, 32'h123, 1'b0};
    addrs = '{12'hF14, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00,
              12'hB80, 12'hB02, 12'hB82, 12'h300, 12'h7C0, 12'hF11};
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 2'b01, 12'h340, 32'h55, 1'b1);
    for (int i = 0; i < 13; i++) begin
      xact(tbl[i].op, tbl[i].addr, tbl[i].wd);
      chk($sformatf("vec%0d_rdata", i), got_rdata, tbl[i].rd);
      chk($sformatf("vec%0d_illegal", i), {31'b0, got_il}, {31'b0, tbl[i].il});
    end
    // Held request: accepted only on alternate cycles (wdata 0, 2, 4)
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 2'b01, 12'h340, i, 1'b0);
    xact(2'b00, 12'h340, 32'h0);
    chk("b2b_last_write", got_rdata, 32'h4);
`ifdef CSR_COUNTERS_EN
    xact(2'b01, 12'hB80, 32'hFFFF_FFFF);
    xact(2'b01, 12'hB00, 32'hFFFF_FFFE);
    xact(2'b00, 12'hB80, 32'h0);
    chk("mcycleh_before_wrap", got_rdata, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b0, 2'b00, 12'h0, 32'h0, 1'b0);
    xact(2'b00, 12'hB80, 32'h0);
    chk("mcycleh_after_wrap", got_rdata, 32'h0);
`else
    xact(2'b00, 12'hB00, 32'h0);
    chk("mcycle_absent_il", {31'b0, got_il}, 32'h1);
    chk("mcycle_absent_rd", got_rdata, 32'h0);
    xact(2'b10, 12'hB82, 32'h0);
    chk("minstreth_absent_il", {31'b0, got_il}, 32'h1);
`endif
    // Reset in the response cycle abandons the response and clears mscratch
    cycle(1'b0, 1'b1, 2'b01, 12'h340, 32'h5, 1'b0);
    cycle(1'b1, 1'b0, 2'b00, 12'h0, 32'h0, 1'b0);
    xact(2'b00, 12'h340, 32'h0);
    chk("rst_in_resp_read", got_rdata, 32'h0);
    for (int i = 0; i < 500; i++) begin
      logic [31:0] wd;
      wd = ($urandom % 4 == 0) ? 32'h0 : $urandom;
      cycle(1'($urandom % 64 == 0), 1'($urandom % 3 != 0), 2'($urandom),
            addrs[$urandom % 12], wd, 1'($urandom % 2));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
